// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: op codes, FSM states, shift-op classifier.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_XOR  = 3'd3,
        OP_DIFF = 3'd4,
        OP_SLL  = 3'd5,
        OP_SRL  = 3'd6,
        OP_SRA  = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    // Shift ops are the only ones that may take the iterative path.
    function automatic logic is_shift_op(input logic [2:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/alu_shift_step.sv
// One partial shift of the work register by n bits (n never exceeds the per-cycle step).
// Latency: combinational.
// Backpressure: none; the owning FSM decides when the output is used.
module alu_shift_step
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]   dat_i,
    input  logic [2:0]         op_i,
    input  logic [SHAMT_W-1:0] n_i,
    output logic [WIDTH-1:0]   dat_o
);

    // Select shift direction/fill by the latched shift op; non-shift codes pass through.
    always_comb begin
        dat_o = dat_i;
        case (alu_op_e'(op_i))
            OP_SLL:  dat_o = dat_i << n_i;
            OP_SRL:  dat_o = dat_i >> n_i;
            OP_SRA:  dat_o = $unsigned($signed(dat_i) >>> n_i);
            default: dat_o = dat_i;
        endcase
    end

endmodule

// File: rtl/alu_seq_unit.sv
// Handshaked ALU: single-cycle ops plus iterative shifts, registered result and flags.
// Latency: 1 cycle accept->out_valid; shifts with shamt>0 take 1+ceil(shamt/SHIFT_STEP).
// Backpressure: result held while out_ready low; in_ready low while shifting or holding unconsumed.
module alu_seq_unit
    import alu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int SHAMT_W    = $clog2(WIDTH),
    parameter int SHIFT_STEP = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               carry,
    output logic               zero,
    output logic               msb,
    output logic               busy
);

    // Remaining count never exceeds WIDTH-1, so capping the step there is lossless
    // and keeps the step constant inside the shift-amount width.
    localparam int                 STEP_CAP = (SHIFT_STEP >= WIDTH) ? WIDTH - 1 : SHIFT_STEP;
    localparam logic [SHAMT_W-1:0] STEP_L   = SHAMT_W'(STEP_CAP);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [SHAMT_W-1:0] rem_q, rem_d;
    logic [2:0]         sop_q, sop_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               carry_q, carry_d;
    logic               zero_q, zero_d;
    logic               msb_q, msb_d;

    logic [WIDTH:0]     add_c, sub_c;
    logic [WIDTH-1:0]   x_c, op_res_c, shifted_c;
    logic               op_carry_c, take_c, load_c;
    logic [SHAMT_W-1:0] step_n;

    // Single-cycle result for the op on the input port (shifts only land here when shamt==0).
    always_comb begin
        add_c      = {1'b0, a} + {1'b0, b};
        sub_c      = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        x_c        = a ^ b;
        op_res_c   = '0;
        op_carry_c = 1'b0;
        case (alu_op_e'(op))
            OP_ADD: begin
                op_res_c   = add_c[WIDTH-1:0];
                op_carry_c = add_c[WIDTH];
            end
            OP_SUB: begin
                op_res_c   = sub_c[WIDTH-1:0];
                op_carry_c = sub_c[WIDTH];
            end
            OP_AND:  op_res_c = a & b;
            OP_XOR:  op_res_c = x_c;
            OP_DIFF: begin
                // Descending scan so the lowest differing bit is the last one written.
                for (int i = WIDTH - 1; i >= 0; i--) begin
                    if (x_c[i]) op_res_c = WIDTH'(i);
                end
            end
            OP_SLL, OP_SRL, OP_SRA: op_res_c = a;
            default: op_res_c = '0;
        endcase
    end

    assign step_n = (rem_q > STEP_L) ? STEP_L : rem_q;

    alu_shift_step #(
        .WIDTH  (WIDTH),
        .SHAMT_W(SHAMT_W)
    ) u_shift_step (
        .dat_i(work_q),
        .op_i (sop_q),
        .n_i  (step_n),
        .dat_o(shifted_c)
    );

    // FSM next state, handshake and result-load decisions.
    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        rem_d    = rem_q;
        sop_d    = sop_q;
        result_d = result_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        msb_d    = msb_q;
        load_c   = 1'b0;
        in_ready = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready);
        take_c   = in_valid && in_ready;

        case (state_q)
            ST_IDLE: ;
            ST_SHIFT: begin
                work_d = shifted_c;
                rem_d  = rem_q - step_n;
                if (rem_d == '0) begin
                    result_d = shifted_c;
                    carry_d  = 1'b0;
                    load_c   = 1'b1;
                    state_d  = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready && !in_valid) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Accept path is shared by IDLE and the drain-and-accept case in HOLD.
        if (take_c) begin
            if (is_shift_op(op) && (shamt != '0)) begin
                work_d  = a;
                rem_d   = shamt;
                sop_d   = op;
                state_d = ST_SHIFT;
            end else begin
                result_d = op_res_c;
                carry_d  = op_carry_c;
                load_c   = 1'b1;
                state_d  = ST_HOLD;
            end
        end

        // Flags follow the registered result, so they only move when it loads.
        if (load_c) begin
            zero_d = (result_d == '0);
            msb_d  = result_d[WIDTH-1];
        end
    end

    // State, work and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            work_q   <= '0;
            rem_q    <= '0;
            sop_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            msb_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            rem_q    <= rem_d;
            sop_q    <= sop_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            msb_q    <= msb_d;
        end
    end

    assign out_valid = (state_q == ST_HOLD);
    assign busy      = (state_q == ST_SHIFT);
    assign result    = result_q;
    assign carry     = carry_q;
    assign zero      = zero_q;
    assign msb       = msb_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Scoreboard bench: driver pushes expected responses on accept, monitor pops on each output transfer.
// A second instance with an 8-bit shift step checks the shortened shift latency.
module tb_alu_seq_unit;
    import alu_pkg::*;

    localparam int STEP = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [2:0]  op;
    logic [31:0] a, b, result;
    logic [4:0]  shamt;
    logic        carry, zero, msb, busy;

    logic        in_valid8, in_ready8, out_valid8;
    logic        out_ready8 = 1'b1;
    logic [2:0]  op8;
    logic [31:0] a8, b8, result8;
    logic [4:0]  shamt8;
    logic        carry8, zero8, msb8, busy8;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rdy_mode;
    logic rnd_rdy = 1'b1;

    typedef struct {
        logic [31:0] res;
        logic        carry;
        int          lat;
        int          acc;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    assign out_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 2) ? 1'b0 : rnd_rdy;

    alu_seq_unit #(.WIDTH(32), .SHAMT_W(5), .SHIFT_STEP(STEP)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a(a), .b(b), .shamt(shamt), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carry(carry), .zero(zero), .msb(msb), .busy(busy)
    );

    alu_seq_unit #(.WIDTH(32), .SHAMT_W(5), .SHIFT_STEP(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .op(op8),
        .a(a8), .b(b8), .shamt(shamt8), .out_valid(out_valid8), .out_ready(out_ready8),
        .result(result8), .carry(carry8), .zero(zero8), .msb(msb8), .busy(busy8)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: plain arithmetic from the op definitions, latency from the shift-step rule.
    function automatic exp_t model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                   input logic [4:0] s);
        exp_t        e;
        logic [32:0] wide;
        logic [31:0] d;
        e.res = '0; e.carry = 1'b0; e.lat = 1; e.acc = 0;
        case (o)
            3'd0: begin wide = {1'b0, x} + {1'b0, y}; e.res = wide[31:0]; e.carry = wide[32]; end
            3'd1: begin e.res = x - y; e.carry = (x >= y); end
            3'd2: e.res = x & y;
            3'd3: e.res = x ^ y;
            3'd4: begin
                d = x ^ y;
                for (int i = 0; i < 32; i++) begin
                    if (d[i]) begin e.res = 32'(i); break; end
                end
            end
            3'd5: e.res = x << s;
            3'd6: e.res = x >> s;
            default: e.res = (x >> s) | (x[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
        endcase
        if (o >= 3'd5 && s != 5'd0) e.lat = 1 + (int'(s) + STEP - 1) / STEP;
        return e;
    endfunction

    // Present one op and hold it until accepted; record the expected response at acceptance.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [4:0] s, input bit use_ref, input logic [31:0] er, input logic ec);
        exp_t e;
        bit   done = 1'b0;
        e = model(o, x, y, s);
        if (!use_ref) begin e.res = er; e.carry = ec; end
        in_valid = 1'b1; op = o; a = x; b = y; shamt = s;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (in_ready) begin e.acc = cyc; exp_q.push_back(e); done = 1'b1; end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!done) chk("accept_timeout", 64'(done), 64'd1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin @(negedge clk); n++; end
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    initial forever begin @(posedge clk); cyc++; end

    initial forever begin @(posedge clk); #1; rnd_rdy = ($urandom_range(0, 3) != 0); end

    // Monitor: latency at first valid, stability while stalled, values on transfer.
    initial begin
        bit          seen = 1'b0;
        bit          held = 1'b0;
        int          first_cyc = 0;
        logic [31:0] h_res = '0;
        logic        h_carry = 1'b0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid) begin
                if (!seen) begin seen = 1'b1; first_cyc = cyc; end
                if (!out_ready) begin
                    if (held) chk("hold_stable", 64'({h_carry, h_res}), 64'({carry, result}));
                    held = 1'b1; h_res = result; h_carry = carry;
                end else begin
                    held = 1'b0;
                    seen = 1'b0;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_out", 64'(exp_q.size()), 64'd1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("result",  64'(result), 64'(e.res));
                        chk("carry",   64'(carry),  64'(e.carry));
                        chk("zero",    64'(zero),   64'(e.res == 32'd0));
                        chk("msb",     64'(msb),    64'(e.res[31]));
                        chk("latency", 64'(first_cyc - e.acc), 64'(e.lat));
                    end
                end
            end else begin
                held = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  o;
        logic [31:0] x, y;
        logic [4:0]  s;
        bit          ov_seen;
        bit          got;
        int          n;

        rst = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0; shamt = '0; rdy_mode = 0;
        in_valid8 = 1'b0; op8 = '0; a8 = '0; b8 = '0; shamt8 = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result",    64'(result),    64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_flags",     64'({carry, zero, msb}), 64'd0);
        chk("rst_busy",      64'(busy),      64'd0);

        // Directed single-cycle ops with fixed expectations, back to back.
        @(posedge clk); #1;
        issue(OP_ADD,  32'hFFFF_FFFF, 32'd1,          5'd0, 1'b0, 32'h0,         1'b1);
        issue(OP_SUB,  32'd5,         32'd7,          5'd0, 1'b0, 32'hFFFF_FFFE, 1'b0);
        issue(OP_SUB,  32'd7,         32'd5,          5'd0, 1'b0, 32'd2,         1'b1);
        issue(OP_DIFF, 32'h0000_00F0, 32'h0000_0030, 5'd0, 1'b0, 32'd6,         1'b0);
        issue(OP_DIFF, 32'hCAFE_0001, 32'hCAFE_0001, 5'd0, 1'b0, 32'd0,         1'b0);
        issue(OP_SRA,  32'h8000_0000, 32'd0,          5'd31, 1'b0, 32'hFFFF_FFFF, 1'b0);
        @(negedge clk);
        chk("shift_busy",     64'(busy),     64'd1);
        chk("shift_in_ready", 64'(in_ready), 64'd0);
        wait_drain();

        // Stall three cycles in HOLD, then drain and accept in the same cycle.
        @(posedge clk); #1;
        rdy_mode = 2;
        issue(OP_ADD, 32'd3, 32'd4, 5'd0, 1'b0, 32'd7, 1'b0);
        repeat (4) @(posedge clk);
        #1 rdy_mode = 0;
        issue(OP_ADD, 32'd10, 32'd20, 5'd0, 1'b0, 32'd30, 1'b0);
        wait_drain();

        // Randomised ops under random consumer backpressure.
        @(posedge clk); #1;
        rdy_mode = 1;
        for (int k = 0; k < 80; k++) begin
            o = 3'($urandom_range(0, 7));
            x = $urandom;
            y = ($urandom_range(0, 4) == 0) ? x : $urandom;
            s = 5'($urandom_range(0, 31));
            issue(o, x, y, s, 1'b1, 32'h0, 1'b0);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        rdy_mode = 0;
        wait_drain();

        // Reset in the middle of a shift: nothing may be emitted afterwards.
        @(posedge clk); #1;
        issue(OP_SRA, 32'h1234_5678, 32'd0, 5'd20, 1'b1, 32'h0, 1'b0);
        repeat (3) @(negedge clk);
        chk("mid_busy", 64'(busy), 64'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        void'(exp_q.pop_back());
        @(negedge clk);
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        chk("post_rst_busy",     64'(busy),     64'd0);
        ov_seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) ov_seen = 1'b1;
        end
        chk("rst_no_emit", 64'(ov_seen), 64'd0);

        // Eight-bit shift step: SRA by 31 takes 1 + 4 cycles.
        @(posedge clk); #1;
        in_valid8 = 1'b1; op8 = OP_SRA; a8 = 32'h8000_0000; b8 = 32'd0; shamt8 = 5'd31;
        @(negedge clk);
        chk("s8_in_ready", 64'(in_ready8), 64'd1);
        @(posedge clk); #1 in_valid8 = 1'b0;
        n = 0; got = 1'b0;
        while (!got && n < 60) begin
            @(negedge clk);
            n++;
            if (out_valid8) got = 1'b1;
        end
        chk("s8_latency", 64'(n),       64'd5);
        chk("s8_result",  64'(result8), 64'hFFFF_FFFF);
        chk("s8_flags",   64'({carry8, zero8, msb8, busy8}), 64'b0010);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
